// File: rtl/locking_rr_port_sched_pkg.sv
// Shared definitions for the locking round-robin port scheduler:
// state encoding and a one-hot rotate helper.
package locking_rr_port_sched_pkg;

  localparam logic STATE_IDLE   = 1'b0;
  localparam logic STATE_LOCKED = 1'b1;

  // Widest requester vector the rotate helper handles
  localparam int unsigned MAX_REQS = 64;

  typedef enum logic {
    ST_IDLE   = STATE_IDLE,
    ST_LOCKED = STATE_LOCKED
  } state_t;

  // Rotate the low n bits of vec left by one; bit n-1 wraps to bit 0
  function automatic logic [MAX_REQS-1:0] rotl1_onehot(
    input logic [MAX_REQS-1:0] vec,
    input int unsigned         n
  );
    logic [MAX_REQS-1:0] res;
    res = '0;
    for (int unsigned i = 0; i < MAX_REQS; i++) begin
      if (i < n) begin
        if (i == n - 32'd1) begin
          res[0] = vec[i];
        end else begin
          res[i + 32'd1] = vec[i];
        end
      end else begin
        res[i] = 1'b0;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/locking_rr_port_sched_rr_grant_logic.sv
// Combinational round-robin picker: scans reqs circularly starting at the
// one-hot priority bit, using a doubled token chain so no loop is formed.
module rr_grant_logic #(
  parameter int unsigned p_num_reqs = 4
) (
  input  logic [p_num_reqs-1:0] prio,
  input  logic [p_num_reqs-1:0] reqs,
  output logic [p_num_reqs-1:0] grants
);

  logic [2*p_num_reqs:0]   token_s;
  logic [2*p_num_reqs-1:0] hit_s;

  // Token enters at the priority bit in the first copy only and dies at the first request
  always_comb begin
    token_s = '0;
    hit_s   = '0;
    for (int unsigned i = 0; i < 2 * p_num_reqs; i++) begin
      logic live;
      if (i < p_num_reqs) begin
        live = token_s[i] | prio[i % p_num_reqs];
      end else begin
        live = token_s[i];
      end
      hit_s[i]       = live & reqs[i % p_num_reqs];
      token_s[i + 1] = live & ~reqs[i % p_num_reqs];
    end
    grants = hit_s[p_num_reqs-1:0] | hit_s[2*p_num_reqs-1:p_num_reqs];
  end

endmodule

// File: rtl/locking_rr_port_sched.sv
// Round-robin scheduler sharing one val/rdy port among requesters; a grant
// is held until a last beat is accepted, then priority rotates past the winner.
module locking_rr_port_sched
  import locking_rr_port_sched_pkg::*;
#(
  parameter int unsigned p_num_reqs  = 4,
  parameter int unsigned p_msg_nbits = 32
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [p_num_reqs-1:0]             in_val,
  output logic [p_num_reqs-1:0]             in_rdy,
  input  logic [p_num_reqs*p_msg_nbits-1:0] in_msg,
  input  logic [p_num_reqs-1:0]             in_last,
  output logic                              out_val,
  input  logic                              out_rdy,
  output logic [p_msg_nbits-1:0]            out_msg,
  output logic                              out_last,
  output logic [p_num_reqs-1:0]             out_owner,
  output logic                              busy
);

  localparam logic [p_num_reqs-1:0] PRIO_RESET = {{(p_num_reqs-1){1'b0}}, 1'b1};

  state_t                  state_r, state_s;
  logic [p_num_reqs-1:0]   prio_r, prio_s;
  logic [p_num_reqs-1:0]   owner_r, owner_s;
  logic [p_num_reqs-1:0]   grant_s;
  logic [p_num_reqs-1:0]   sel_s;
  logic [p_msg_nbits-1:0]  msg_s;
  logic                    val_s;
  logic                    last_s;
  logic                    fire_s;
  logic [MAX_REQS-1:0]     rot_in_s;
  logic [MAX_REQS-1:0]     rot_out_s;

  rr_grant_logic #(
    .p_num_reqs (p_num_reqs)
  ) u_grant (
    .prio   (prio_r),
    .reqs   (in_val),
    .grants (grant_s)
  );

  // Select the routed requester and mux its beat onto the shared port
  always_comb begin
    if (state_r == ST_LOCKED) begin
      sel_s = owner_r;
    end else begin
      sel_s = grant_s;
    end
    msg_s = '0;
    for (int unsigned i = 0; i < p_num_reqs; i++) begin
      msg_s = msg_s | (in_msg[i*p_msg_nbits +: p_msg_nbits] & {p_msg_nbits{sel_s[i]}});
    end
    val_s     = |(in_val & sel_s);
    last_s    = |(in_last & sel_s);
    fire_s    = val_s & out_rdy;
    rot_in_s  = '0;
    rot_in_s[p_num_reqs-1:0] = sel_s;
    rot_out_s = rotl1_onehot(rot_in_s, p_num_reqs);
  end

  // Next-state logic: lock on any unfinished grant, release and rotate on last beat
  always_comb begin
    state_s = state_r;
    prio_s  = prio_r;
    owner_s = owner_r;
    case (state_r)
      ST_IDLE: begin
        if (|grant_s) begin
          if (fire_s && last_s) begin
            prio_s = rot_out_s[p_num_reqs-1:0];
          end else begin
            state_s = ST_LOCKED;
            owner_s = grant_s;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOCKED: begin
        if (fire_s && last_s) begin
          state_s = ST_IDLE;
          prio_s  = rot_out_s[p_num_reqs-1:0];
          owner_s = '0;
        end else begin
          state_s = ST_LOCKED;
        end
      end
      default: begin
        state_s = ST_IDLE;
        prio_s  = PRIO_RESET;
        owner_s = '0;
      end
    endcase
  end

  // State, priority and owner registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      prio_r  <= PRIO_RESET;
      owner_r <= '0;
    end else begin
      state_r <= state_s;
      prio_r  <= prio_s;
      owner_r <= owner_s;
    end
  end

  // Port outputs, forced quiet while reset is held
  always_comb begin
    if (reset) begin
      out_val   = 1'b0;
      out_msg   = '0;
      out_last  = 1'b0;
      in_rdy    = '0;
      out_owner = '0;
      busy      = 1'b0;
    end else begin
      out_val   = val_s;
      out_msg   = msg_s;
      out_last  = last_s;
      in_rdy    = sel_s & {p_num_reqs{out_rdy}};
      out_owner = sel_s;
      busy      = (state_r == ST_LOCKED);
    end
  end

endmodule

// File: tb/tb_locking_rr_port_sched.sv
// Bench for locking_rr_port_sched: directed scenarios plus randomized traffic
// checked against an integer-level arbitration model.
module tb_locking_rr_port_sched;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   in_val, in_rdy, in_last, out_owner;
  logic [N*W-1:0] in_msg;
  logic           out_val, out_rdy, out_last, busy;
  logic [W-1:0]   out_msg;

  logic [1:0]     in_val2, in_rdy2, in_last2, out_owner2;
  logic [15:0]    in_msg2;
  logic           out_val2, out_rdy2, out_last2, busy2;
  logic [7:0]     out_msg2;

  int errors = 0;
  int checks = 0;

  // model state: integer owner/priority index
  bit m_locked;
  int m_owner;
  int m_prio;
  int m_sel;
  logic         e_val, e_last, e_busy;
  logic [N-1:0] e_owner, e_rdy;
  logic [W-1:0] e_msg;

  always #5 clk = ~clk;

  locking_rr_port_sched #(.p_num_reqs(N), .p_msg_nbits(W)) u_dut (
    .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy), .in_msg(in_msg),
    .in_last(in_last), .out_val(out_val), .out_rdy(out_rdy), .out_msg(out_msg),
    .out_last(out_last), .out_owner(out_owner), .busy(busy)
  );

  locking_rr_port_sched #(.p_num_reqs(2), .p_msg_nbits(8)) u_dut2 (
    .clk(clk), .reset(reset), .in_val(in_val2), .in_rdy(in_rdy2), .in_msg(in_msg2),
    .in_last(in_last2), .out_val(out_val2), .out_rdy(out_rdy2), .out_msg(out_msg2),
    .out_last(out_last2), .out_owner(out_owner2), .busy(busy2)
  );

  task automatic model_eval();
    m_sel = -1;
    if (m_locked) m_sel = m_owner;
    else
      for (int k = 0; k < N; k++)
        if (m_sel < 0 && in_val[(m_prio + k) % N]) m_sel = (m_prio + k) % N;
    e_owner = '0; e_rdy = '0; e_msg = '0; e_val = 1'b0; e_last = 1'b0;
    e_busy = m_locked;
    if (m_sel >= 0) begin
      e_owner[m_sel] = 1'b1;
      e_rdy[m_sel]   = out_rdy;
      e_val          = in_val[m_sel];
      e_last         = in_last[m_sel];
      e_msg          = in_msg[m_sel*W +: W];
    end
    if (reset) begin
      e_owner = '0; e_rdy = '0; e_msg = '0; e_val = 1'b0; e_last = 1'b0; e_busy = 1'b0;
    end
  endtask

  task automatic tick();
    bit fire;
    model_eval();
    fire = e_val && out_rdy;
    @(posedge clk);
    if (reset) begin
      m_locked = 1'b0; m_owner = -1; m_prio = 0;
    end else if (!m_locked) begin
      if (m_sel >= 0) begin
        if (fire && e_last) m_prio = (m_sel + 1) % N;
        else begin m_locked = 1'b1; m_owner = m_sel; end
      end
    end else if (fire && e_last) begin
      m_locked = 1'b0; m_prio = (m_owner + 1) % N; m_owner = -1;
    end
    @(negedge clk);
  endtask

  task automatic set_in(input logic [N-1:0] v, input logic [N-1:0] l, input logic r);
    in_val = v; in_last = l; out_rdy = r;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_in(4'b1111, 4'b1111, 1'b1);
    #1;
    checks++;
    if ({out_val, out_last, busy, in_rdy, out_owner} !== 11'd0 || out_msg !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs got val=%b last=%b busy=%b rdy=%b owner=%b msg=%h expected all zero",
               out_val, out_last, busy, in_rdy, out_owner, out_msg);
    end
    tick(); tick();
    reset = 1'b0;
    #1;
    checks++;
    if (out_owner !== 4'b0001 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_grant got owner=%b busy=%b expected owner=0001 busy=0", out_owner, busy);
    end
  endtask

  task automatic test_rotation();
    logic [3:0] exp_seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    set_in(4'b1111, 4'b1111, 1'b1);
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (out_owner !== exp_seq[c] || in_rdy !== exp_seq[c] || busy !== 1'b0) begin
        errors++;
        $display("FAIL rotation[%0d] got owner=%b rdy=%b busy=%b expected %b/%b/0",
                 c, out_owner, in_rdy, busy, exp_seq[c], exp_seq[c]);
      end
      tick();
    end
  endtask

  task automatic test_burst();
    set_in(4'b0010, 4'b1111, 1'b1);
    tick();
    for (int b = 0; b < 3; b++) begin
      set_in(4'b0111, (b == 2) ? 4'b0111 : 4'b0011, 1'b1);
      #1;
      checks++;
      if (out_owner !== 4'b0100 || in_rdy !== 4'b0100 || busy !== (b != 0) ||
          out_last !== (b == 2) || out_msg !== 32'hA000_0002) begin
        errors++;
        $display("FAIL burst_beat%0d got owner=%b rdy=%b busy=%b last=%b msg=%h expected 0100/0100/%0d/%0d/a0000002",
                 b, out_owner, in_rdy, busy, out_last, out_msg, b != 0, b == 2);
      end
      tick();
    end
    set_in(4'b0011, 4'b1111, 1'b1);
    #1;
    checks++;
    if (out_owner !== 4'b0001 || busy !== 1'b0) begin
      errors++;
      $display("FAIL burst_next_grant got owner=%b busy=%b expected 0001/0", out_owner, busy);
    end
    tick();
  endtask

  task automatic test_backpressure();
    in_msg[63:32] = 32'hDEAD_BEEF;
    for (int c = 0; c < 4; c++) begin
      set_in((c == 0) ? 4'b0010 : 4'b0011, 4'b1111, c == 3);
      #1;
      checks++;
      if (out_owner !== 4'b0010 || out_msg !== 32'hDEAD_BEEF || out_val !== 1'b1 ||
          in_rdy !== ((c == 3) ? 4'b0010 : 4'b0000) || busy !== (c != 0)) begin
        errors++;
        $display("FAIL backpressure[%0d] got owner=%b msg=%h val=%b rdy=%b busy=%b expected 0010/deadbeef/1/%b/%0d",
                 c, out_owner, out_msg, out_val, in_rdy, busy, (c == 3) ? 4'b0010 : 4'b0000, c != 0);
      end
      tick();
    end
  endtask

  task automatic test_owner_drop();
    set_in(4'b1000, 4'b0000, 1'b1);
    #1;
    checks++;
    if (out_owner !== 4'b1000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL drop_start got owner=%b busy=%b expected 1000/0", out_owner, busy);
    end
    tick();
    for (int c = 0; c < 2; c++) begin
      set_in(4'b0111, 4'b1111, 1'b1);
      #1;
      checks++;
      if (out_val !== 1'b0 || busy !== 1'b1 || in_rdy !== 4'b1000 || out_owner !== 4'b1000) begin
        errors++;
        $display("FAIL drop_gap[%0d] got val=%b busy=%b rdy=%b owner=%b expected 0/1/1000/1000",
                 c, out_val, busy, in_rdy, out_owner);
      end
      tick();
    end
    set_in(4'b1111, 4'b1000, 1'b1);
    #1;
    checks++;
    if (out_val !== 1'b1 || out_last !== 1'b1 || in_rdy !== 4'b1000) begin
      errors++;
      $display("FAIL drop_resume got val=%b last=%b rdy=%b expected 1/1/1000", out_val, out_last, in_rdy);
    end
    tick();
    set_in(4'b1111, 4'b1111, 1'b1);
    #1;
    checks++;
    if (out_owner !== 4'b0001 || busy !== 1'b0) begin
      errors++;
      $display("FAIL drop_wrap got owner=%b busy=%b expected 0001/0", out_owner, busy);
    end
    tick();
  endtask

  task automatic test_async_reset();
    set_in(4'b0010, 4'b0000, 1'b1);
    tick();
    set_in(4'b0011, 4'b0000, 1'b1);
    #1;
    checks++;
    if (busy !== 1'b1 || out_owner !== 4'b0010) begin
      errors++;
      $display("FAIL areset_pre got busy=%b owner=%b expected 1/0010", busy, out_owner);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || out_val !== 1'b0 || out_owner !== 4'b0000 || in_rdy !== 4'b0000) begin
      errors++;
      $display("FAIL areset_now got busy=%b val=%b owner=%b rdy=%b expected 0/0/0000/0000",
               busy, out_val, out_owner, in_rdy);
    end
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (out_owner !== 4'b0001 || in_rdy !== 4'b0001 || busy !== 1'b0) begin
      errors++;
      $display("FAIL areset_after got owner=%b rdy=%b busy=%b expected 0001/0001/0", out_owner, in_rdy, busy);
    end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      in_val  = N'($urandom_range(0, 15));
      in_last = N'($urandom);
      out_rdy = ($urandom_range(0, 3) != 0);
      in_msg  = {$urandom, $urandom, $urandom, $urandom};
      #1;
      model_eval();
      checks++;
      if (out_owner !== e_owner || in_rdy !== e_rdy || busy !== e_busy) begin
        errors++;
        $display("FAIL rand_ctrl[%0d] got owner=%b rdy=%b busy=%b expected %b/%b/%b",
                 c, out_owner, in_rdy, busy, e_owner, e_rdy, e_busy);
      end
      checks++;
      if (out_val !== e_val || out_last !== e_last || out_msg !== e_msg) begin
        errors++;
        $display("FAIL rand_data[%0d] got val=%b last=%b msg=%h expected %b/%b/%h",
                 c, out_val, out_last, out_msg, e_val, e_last, e_msg);
      end
      checks++;
      if ($countones(in_rdy) > 1 || $countones(out_owner) > 1) begin
        errors++;
        $display("FAIL rand_onehot[%0d] got rdy=%b owner=%b expected at most one bit", c, in_rdy, out_owner);
      end
      tick();
    end
  endtask

  task automatic test_two_req();
    set_in(4'b0000, 4'b0000, 1'b0);
    in_val2 = 2'b11; in_last2 = 2'b11; out_rdy2 = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (out_owner2 !== ((c % 2 == 0) ? 2'b01 : 2'b10) || out_val2 !== 1'b1) begin
        errors++;
        $display("FAIL two_req[%0d] got owner=%b val=%b expected %b/1",
                 c, out_owner2, out_val2, (c % 2 == 0) ? 2'b01 : 2'b10);
      end
      tick();
    end
    in_val2 = 2'b00;
  endtask

  initial begin
    m_locked = 1'b0; m_owner = -1; m_prio = 0;
    reset = 1'b1;
    in_val = '0; in_last = '0; out_rdy = 1'b0;
    in_msg = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
    in_val2 = '0; in_last2 = '0; out_rdy2 = 1'b0; in_msg2 = 16'h5AA5;
    @(negedge clk);
    test_reset();
    test_rotation();
    test_burst();
    test_backpressure();
    test_owner_drop();
    test_async_reset();
    test_random();
    test_two_req();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
